// File: rtl/req_fifo_sched_pkg.sv
// Shared types and helpers for the request FIFO scheduler: DELIM byte,
// FSM encoding, clog2 and the DELIM-word builder.
package req_sched_pkg;

    localparam logic [7:0] DELIM     = 8'hee;
    localparam int         MAX_WIDTH = 512;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Callers slice the low WIDTH bits; the upper bits are always zero.
    function automatic logic [MAX_WIDTH-1:0] delim_word();
        return {{(MAX_WIDTH-8){1'b0}}, DELIM};
    endfunction

    function automatic logic is_delim(input logic [7:0] low_byte);
        return low_byte == DELIM;
    endfunction

endpackage

// File: rtl/req_fifo_sched_if.sv
// Bundle of the per-FIFO read side, the TX stream and the status outputs.
// master = scheduler side, slave = FIFO/PHY/bench side.
interface req_fifo_sched_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
);
    localparam int IW = req_sched_pkg::clog2(NREQ);

    logic [NREQ-1:0]       fifo_empty;
    logic [NREQ*WIDTH-1:0] fifo_rdata;
    logic [NREQ-1:0]       fifo_rd;
    logic [WIDTH-1:0]      tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;
    logic [IW-1:0]         tx_src;
    logic                  busy;
    logic                  abort;

    // tx word moves when tx_valid & tx_ready at a rising edge; while tx_valid
    // is high and tx_ready is low, tx_data/tx_last/tx_src hold. fifo_rd pops
    // the FIFO head at the same edge and is only raised for a non-empty FIFO.
    modport master (
        input  fifo_empty, fifo_rdata, tx_ready,
        output fifo_rd, tx_data, tx_valid, tx_last, tx_src, busy, abort
    );

    modport slave (
        output fifo_empty, fifo_rdata, tx_ready,
        input  fifo_rd, tx_data, tx_valid, tx_last, tx_src, busy, abort
    );

endinterface

// File: rtl/req_fifo_sched_rr_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping.
module rr_pick
    import req_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    int idx;

    // Walk offsets from the far end so the nearest offset to ptr wins last.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx[IW-1:0]]) begin
                gnt_idx_o = idx[IW-1:0];
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_fifo_sched.sv
// Round-robin scheduler forwarding whole DELIM-terminated requests from NREQ
// FWFT FIFOs onto one registered TX stream. Optional watchdog: REQ_SCHED_TIMEOUT_EN.
module req_fifo_sched
    import req_sched_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    req_fifo_sched_if.master bus
);

    localparam int                     IW         = clog2(NREQ);
    localparam logic [MAX_WIDTH-1:0]   DELIM_FULL = delim_word();
    localparam logic [WIDTH-1:0]       DELIM_WORD = DELIM_FULL[WIDTH-1:0];

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic [IW-1:0]    tx_src_q, tx_src_d;
    logic             abort_q, abort_d;

    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] head;
    logic             head_empty;
    logic             head_delim;
    logic             out_free;
    logic             load;
    logic             fire;
    logic [IW-1:0]    grant_next;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i     (~bus.fifo_empty),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    assign head       = bus.fifo_rdata[grant_q*WIDTH +: WIDTH];
    assign head_empty = bus.fifo_empty[grant_q];
    assign head_delim = is_delim(head[7:0]);
    assign out_free   = ~tx_valid_q | bus.tx_ready;
    assign load       = (state_q == XFER) & ~head_empty & out_free;
    assign grant_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef REQ_SCHED_TIMEOUT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign fire = (state_q == XFER) & head_empty & out_free
                & (stall_cnt_q >= 16'(TIMEOUT));

    // Saturates so a blocked output register cannot wrap the count back to 0.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load || fire) begin
            stall_cnt_d = '0;
        end else if (state_q == XFER && head_empty && stall_cnt_q != 16'hffff) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign fire           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if ((load && head_delim) || fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd = '0;
        if (load) bus.fifo_rd[grant_q] = 1'b1;
    end

    assign bus.busy = (state_q == XFER);

    // A load and an empty-side watchdog fire are mutually exclusive.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        tx_src_d   = tx_src_q;
        abort_d    = fire;
        if (load) begin
            tx_data_d  = head;
            tx_valid_d = 1'b1;
            tx_last_d  = head_delim;
            tx_src_d   = grant_q;
        end else if (fire) begin
            tx_data_d  = DELIM_WORD;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
            tx_src_d   = grant_q;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_src_q   <= '0;
            abort_q    <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_src_q   <= tx_src_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_last  = tx_last_q;
    assign bus.tx_src   = tx_src_q;
    assign bus.abort    = abort_q;

endmodule
